// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the two-requester ALU arbiter.
//   Opcode constants (ALU_ADD..ALU_COPYA), requester-id width and ids,
//   and the operation bundle carried from a requester into the ALU.
package alu_pkg;

  localparam int REQ_ID_W = 1;
  localparam int DATA_W   = 32;
  localparam int OP_W     = 4;

  localparam logic [REQ_ID_W-1:0] REQ_ID0 = REQ_ID_W'(0);
  localparam logic [REQ_ID_W-1:0] REQ_ID1 = REQ_ID_W'(1);

  localparam logic [OP_W-1:0] ALU_ADD   = 4'd1;
  localparam logic [OP_W-1:0] ALU_SUB   = 4'd2;
  localparam logic [OP_W-1:0] ALU_AND   = 4'd3;
  localparam logic [OP_W-1:0] ALU_OR    = 4'd4;
  localparam logic [OP_W-1:0] ALU_XOR   = 4'd5;
  localparam logic [OP_W-1:0] ALU_SLT   = 4'd6;
  localparam logic [OP_W-1:0] ALU_SLTU  = 4'd7;
  localparam logic [OP_W-1:0] ALU_SLL   = 4'd8;
  localparam logic [OP_W-1:0] ALU_SRL   = 4'd9;
  localparam logic [OP_W-1:0] ALU_SRA   = 4'd10;
  localparam logic [OP_W-1:0] ALU_COPYA = 4'd11;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
  } alu_req_t;

endpackage

// File: rtl/alu_core.sv
// alu_core -- purely combinational 32-bit ALU shared by both requesters.
//   op   : opcode (alu_pkg constants); undefined opcodes yield 0
//   a, b : operands; shifts use b[4:0] as the shift amount
//   res  : result
//   zero : res == 0
module alu_core
  import alu_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] res,
  output logic              zero
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    res = '0;
    case (op)
      ALU_ADD:   res = a + b;
      ALU_SUB:   res = a - b;
      ALU_AND:   res = a & b;
      ALU_OR:    res = a | b;
      ALU_XOR:   res = a ^ b;
      ALU_SLT:   res = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU:  res = {{(DATA_W-1){1'b0}}, a < b};
      ALU_SLL:   res = a << shamt;
      ALU_SRL:   res = a >> shamt;
      ALU_SRA:   res = $unsigned($signed(a) >>> shamt);
      ALU_COPYA: res = a;
      default:   res = '0;
    endcase
  end

  assign zero = (res == '0);

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter -- round-robin time-sharing of one ALU between two requesters,
// with a single result register returned to whichever requester owns it.
//   clk, reset               : clock, synchronous active-high reset
//   io_reqN_valid/ready      : request handshake, N = 0,1 (ready = grant)
//   io_reqN_a/b/op           : operands and opcode
//   io_respN_valid           : held result belongs to requester N
//   io_resp_ready            : owner consumes the held result this cycle
//   io_resp_out/io_resp_zero : held result and its zero flag
// Optional macro ALU_ARB_PERF_EN adds saturating 16-bit counters:
//   io_perf_grant0/1 (grants per requester), io_perf_stall (cycles with a
//   valid request and no grant).
module alu_arbiter
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              io_req0_valid,
  output logic              io_req0_ready,
  input  logic [DATA_W-1:0] io_req0_a,
  input  logic [DATA_W-1:0] io_req0_b,
  input  logic [OP_W-1:0]   io_req0_op,
  input  logic              io_req1_valid,
  output logic              io_req1_ready,
  input  logic [DATA_W-1:0] io_req1_a,
  input  logic [DATA_W-1:0] io_req1_b,
  input  logic [OP_W-1:0]   io_req1_op,
  output logic              io_resp0_valid,
  output logic              io_resp1_valid,
  input  logic              io_resp_ready,
  output logic [DATA_W-1:0] io_resp_out,
  output logic              io_resp_zero
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [15:0]       io_perf_grant0,
  output logic [15:0]       io_perf_grant1,
  output logic [15:0]       io_perf_stall
`endif
);

  logic [DATA_W-1:0]   res_q;
  logic                zero_q;
  logic [REQ_ID_W-1:0] owner_q;
  logic                full_q;
  logic [REQ_ID_W-1:0] prio_q;

  alu_req_t req0, req1, sel;
  logic     slot_free, grant0, grant1, grant_any;

  assign req0 = '{a: io_req0_a, b: io_req0_b, op: io_req0_op};
  assign req1 = '{a: io_req1_a, b: io_req1_b, op: io_req1_op};

  // A consume in the same cycle frees the slot, giving 1 op/cycle throughput.
  // Grants are masked during reset so nothing is accepted in the reset cycle.
  assign slot_free = (!full_q || io_resp_ready) && !reset;

  // Contention goes to prio_q; a lone requester always wins.
  assign grant0 = slot_free && io_req0_valid &&
                  (!io_req1_valid || (prio_q == REQ_ID0));
  assign grant1 = slot_free && io_req1_valid &&
                  (!io_req0_valid || (prio_q == REQ_ID1));
  assign grant_any = grant0 || grant1;

  assign io_req0_ready = grant0;
  assign io_req1_ready = grant1;

  assign sel = grant1 ? req1 : req0;

  logic [DATA_W-1:0] alu_res;
  logic              alu_zero;

  alu_core u_alu (
    .op   (sel.op),
    .a    (sel.a),
    .b    (sel.b),
    .res  (alu_res),
    .zero (alu_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      res_q   <= '0;
      zero_q  <= 1'b0;
      owner_q <= REQ_ID0;
      full_q  <= 1'b0;
      prio_q  <= REQ_ID0;
    end else if (grant_any) begin
      res_q   <= alu_res;
      zero_q  <= alu_zero;
      owner_q <= grant1 ? REQ_ID1 : REQ_ID0;
      full_q  <= 1'b1;
      // Pointer moves to the requester that did not win.
      prio_q  <= grant1 ? REQ_ID0 : REQ_ID1;
    end else if (full_q && io_resp_ready) begin
      full_q  <= 1'b0;
    end
  end

  // Valids are masked in the reset cycle so a discarded result is never seen.
  assign io_resp0_valid = full_q && (owner_q == REQ_ID0) && !reset;
  assign io_resp1_valid = full_q && (owner_q == REQ_ID1) && !reset;
  assign io_resp_out    = full_q ? res_q : '0;
  assign io_resp_zero   = full_q && zero_q;

`ifdef ALU_ARB_PERF_EN
  logic [15:0] grant0_cnt_q, grant1_cnt_q, stall_cnt_q;
  logic        stall;

  assign stall = (io_req0_valid || io_req1_valid) && !grant_any;

  always_ff @(posedge clk) begin
    if (reset) begin
      grant0_cnt_q <= '0;
      grant1_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      if (grant0 && grant0_cnt_q != 16'hFFFF) grant0_cnt_q <= grant0_cnt_q + 16'd1;
      if (grant1 && grant1_cnt_q != 16'hFFFF) grant1_cnt_q <= grant1_cnt_q + 16'd1;
      if (stall  && stall_cnt_q  != 16'hFFFF) stall_cnt_q  <= stall_cnt_q  + 16'd1;
    end
  end

  assign io_perf_grant0 = grant0_cnt_q;
  assign io_perf_grant1 = grant1_cnt_q;
  assign io_perf_stall  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter -- directed vectors for alu_arbiter. The stimulus process
// checks readys and pushes the hand-computed expected response on each
// expected grant; a monitor pops and compares whenever a response is shown.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        io_req0_valid, io_req1_valid;
  logic        io_req0_ready, io_req1_ready;
  logic [31:0] io_req0_a, io_req0_b, io_req1_a, io_req1_b;
  logic [3:0]  io_req0_op, io_req1_op;
  logic        io_resp0_valid, io_resp1_valid, io_resp_ready;
  logic [31:0] io_resp_out;
  logic        io_resp_zero;
`ifdef ALU_ARB_PERF_EN
  logic [15:0] io_perf_grant0, io_perf_grant1, io_perf_stall;
`endif

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .io_req0_valid(io_req0_valid), .io_req0_ready(io_req0_ready),
    .io_req0_a(io_req0_a), .io_req0_b(io_req0_b), .io_req0_op(io_req0_op),
    .io_req1_valid(io_req1_valid), .io_req1_ready(io_req1_ready),
    .io_req1_a(io_req1_a), .io_req1_b(io_req1_b), .io_req1_op(io_req1_op),
    .io_resp0_valid(io_resp0_valid), .io_resp1_valid(io_resp1_valid),
    .io_resp_ready(io_resp_ready), .io_resp_out(io_resp_out),
    .io_resp_zero(io_resp_zero)
`ifdef ALU_ARB_PERF_EN
    , .io_perf_grant0(io_perf_grant0), .io_perf_grant1(io_perf_grant1),
    .io_perf_stall(io_perf_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        owner;
    logic [31:0] res;
    logic        zero;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  logic mon_en = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // One cycle: drive after the edge, check readys at negedge, log expected.
  task automatic step(input logic r,
                      input logic v0, input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] op0,
                      input logic v1, input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] op1,
                      input logic rr, input logic er0, input logic er1,
                      input logic [31:0] exp_res);
    exp_t e;
    @(posedge clk); #1;
    reset = r;
    io_req0_valid = v0; io_req0_a = a0; io_req0_b = b0; io_req0_op = op0;
    io_req1_valid = v1; io_req1_a = a1; io_req1_b = b1; io_req1_op = op1;
    io_resp_ready = rr;
    @(negedge clk);
    chk("ready0", {31'b0, io_req0_ready}, {31'b0, er0});
    chk("ready1", {31'b0, io_req1_ready}, {31'b0, er1});
    if (er0 || er1) begin
      e.owner = er1;
      e.res   = exp_res;
      e.zero  = (exp_res == 32'h0);
      q.push_back(e);
    end
  endtask

  task automatic idle(input logic rr);
    step(1'b0, 1'b0, 0, 0, 4'd0, 1'b0, 0, 0, 4'd0, rr, 1'b0, 1'b0, 32'h0);
  endtask

  // Monitor: compare whatever the DUT presents against the queue head.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (io_resp0_valid || io_resp1_valid) begin
        chk("one_owner", {31'b0, io_resp0_valid && io_resp1_valid}, 32'h0);
        if (q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL spurious_resp: got 0x%08h expected no response", io_resp_out);
        end else begin
          chk("resp_owner", {31'b0, io_resp1_valid}, {31'b0, q[0].owner});
          chk("resp_out", io_resp_out, q[0].res);
          chk("resp_zero", {31'b0, io_resp_zero}, {31'b0, q[0].zero});
          if (io_resp_ready) void'(q.pop_front());
        end
      end else begin
        chk("idle_out", io_resp_out, 32'h0);
      end
    end
  end

  initial begin
    reset = 1'b1; io_resp_ready = 1'b0;
    io_req0_valid = 1'b0; io_req0_a = '0; io_req0_b = '0; io_req0_op = '0;
    io_req1_valid = 1'b0; io_req1_a = '0; io_req1_b = '0; io_req1_op = '0;

    // Reset cycle: requests present, nothing granted, no response.
    step(1'b1, 1'b1, 1, 1, 4'd1, 1'b1, 1, 1, 4'd1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("rst_valid", {30'b0, io_resp0_valid, io_resp1_valid}, 32'h0);

    // Single requester: 5 + 3.
    step(1'b0, 1'b1, 5, 3, 4'd1, 1'b0, 0, 0, 4'd0, 1'b1, 1'b1, 1'b0, 32'd8);
    idle(1'b1);

    // Fresh reset, then both valid: grants 0,1,0,1.
    step(1'b1, 1'b0, 0, 0, 4'd0, 1'b0, 0, 0, 4'd0, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1, 2, 4'd1, 1'b1, 10, 4, 4'd2, 1'b1, 1'b1, 1'b0, 32'd3);
    step(1'b0, 1'b1, 3, 4, 4'd1, 1'b1, 10, 4, 4'd2, 1'b1, 1'b0, 1'b1, 32'd6);
    step(1'b0, 1'b1, 3, 4, 4'd1, 1'b1, 20, 5, 4'd2, 1'b1, 1'b1, 1'b0, 32'd7);
    step(1'b0, 1'b1, 5, 5, 4'd1, 1'b1, 20, 5, 4'd2, 1'b1, 1'b0, 1'b1, 32'd15);

    // req1 sra, then 3 cycles of backpressure with both requesting.
    step(1'b0, 1'b0, 0, 0, 4'd0, 1'b1, 32'h80000000, 4, 4'd10, 1'b1, 1'b0, 1'b1, 32'hF8000000);
    repeat (3)
      step(1'b0, 1'b1, 7, 7, 4'd2, 1'b1, 32'hFF, 32'h0F, 4'd3, 1'b0, 1'b0, 1'b0, 32'h0);
    // Release and regrant in the same cycle (pointer favours req0).
    step(1'b0, 1'b1, 7, 7, 4'd2, 1'b1, 32'hFF, 32'h0F, 4'd3, 1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'hFFFFFFFF, 1, 4'd6, 1'b1, 32'hFF, 32'h0F, 4'd3, 1'b1, 1'b0, 1'b1, 32'h0F);

    // Opcode table, req0 alone, back to back.
    step(1'b0, 1'b1, 32'hFFFFFFFF, 1, 4'd6,  1'b0, 0, 0, 4'd0, 1'b1, 1'b1, 1'b0, 32'd1);
    step(1'b0, 1'b1, 32'hFFFFFFFF, 1, 4'd7,  1'b0, 0, 0, 4'd0, 1'b1, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b1, 32'h1234, 32'h55, 4'd15, 1'b0, 0, 0, 4'd0, 1'b1, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b1, 3, 5, 4'd2,             1'b0, 0, 0, 4'd0, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFE);
    step(1'b0, 1'b1, 32'hF0F0, 32'hFF00, 4'd3, 1'b0, 0, 0, 4'd0, 1'b1, 1'b1, 1'b0, 32'hF000);
    step(1'b0, 1'b1, 32'hF0F0, 32'hFF00, 4'd4, 1'b0, 0, 0, 4'd0, 1'b1, 1'b1, 1'b0, 32'hFFF0);
    step(1'b0, 1'b1, 32'hF0F0, 32'hFF00, 4'd5, 1'b0, 0, 0, 4'd0, 1'b1, 1'b1, 1'b0, 32'h0FF0);
    step(1'b0, 1'b1, 1, 31, 4'd8,            1'b0, 0, 0, 4'd0, 1'b1, 1'b1, 1'b0, 32'h80000000);
    step(1'b0, 1'b1, 1, 32'h21, 4'd8,        1'b0, 0, 0, 4'd0, 1'b1, 1'b1, 1'b0, 32'h2);
    step(1'b0, 1'b1, 32'h80000000, 4, 4'd9,  1'b0, 0, 0, 4'd0, 1'b1, 1'b1, 1'b0, 32'h08000000);
    step(1'b0, 1'b1, 32'h7FFFFFFF, 1, 4'd10, 1'b0, 0, 0, 4'd0, 1'b1, 1'b1, 1'b0, 32'h3FFFFFFF);
    step(1'b0, 1'b1, 1, 32'hFFFFFFFF, 4'd7,  1'b0, 0, 0, 4'd0, 1'b1, 1'b1, 1'b0, 32'd1);
    step(1'b0, 1'b1, 32'h1234, 9, 4'd11,     1'b0, 0, 0, 4'd0, 1'b1, 1'b1, 1'b0, 32'h1234);

    // Hold a result (pointer now at req1), then reset over it.
    idle(1'b0);
    step(1'b1, 1'b1, 1, 1, 4'd1, 1'b1, 2, 2, 4'd1, 1'b1, 1'b0, 1'b0, 32'h0);
    q.delete();
    // After reset: held result gone, pointer back at req0.
    step(1'b0, 1'b1, 2, 2, 4'd1, 1'b1, 9, 1, 4'd2, 1'b1, 1'b1, 1'b0, 32'd4);
    idle(1'b1);
    idle(1'b1);
    chk("queue_drained", q.size(), 32'd0);

`ifdef ALU_ARB_PERF_EN
    mon_en = 1'b0;
    step(1'b1, 1'b0, 0, 0, 4'd0, 1'b0, 0, 0, 4'd0, 1'b1, 1'b0, 1'b0, 32'h0);
    q.delete();
    @(posedge clk); #1;
    reset = 1'b0; io_req0_valid = 1'b1; io_req1_valid = 1'b0; io_resp_ready = 1'b1;
    repeat (70000) @(posedge clk);
    #1 io_req0_valid = 1'b0;
    @(negedge clk);
    chk("perf_grant0", {16'h0, io_perf_grant0}, 32'hFFFF);
    chk("perf_grant1", {16'h0, io_perf_grant1}, 32'h0);
    chk("perf_stall",  {16'h0, io_perf_stall},  32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
